// File: rtl/io_port_pkg.sv
// io_port_pkg: register offsets and STATUS bit positions for io_port_ctrl
package io_port_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_UNDERFLOW = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_RX_COUNT    = 8;

endpackage

// File: rtl/port_fifo.sv
// port_fifo: synchronous flop-array FIFO; push ignored when full, pop ignored when empty
module port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetE,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // stale storage is never exposed: an empty FIFO presents zero
    assign dout    = empty ? '0 : mem[rp];

    // pointers wrap naturally; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (!resetE) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage is not reset; contents behind the pointers are don't-care
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped RX/TX byte channels with valid/ready handshakes
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter int          WIDTH = 8,
    parameter logic [31:0] BASE  = 32'h800
) (
    input  logic             clk,
    input  logic             resetE,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    output logic [31:0]      ReadData,
    output logic             hit,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       sel;
    logic             rd_data, wr_data, clr;
    logic [WIDTH-1:0] rx_dout;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]    rx_count, tx_count;
    logic             rx_underflow, tx_overflow;
    logic [31:0]      status;
    logic             unused_bits;

    assign hit      = DataAdr[31:4] == BASE[31:4];
    assign sel      = DataAdr[3:2];
    assign rd_data  = hit & MemtoReg & (sel == REG_DATA);
    assign wr_data  = hit & MemWrite & (sel == REG_DATA);
    assign clr      = hit & MemWrite & (sel == REG_CTRL) & WriteData[0];
    assign rx_ready = resetE & ~rx_full;
    assign tx_valid = ~tx_empty;
    assign unused_bits = ^{DataAdr[1:0], WriteData[31:WIDTH], tx_count};

    port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
        .clk    (clk),
        .resetE (resetE),
        .push   (rx_valid & rx_ready),
        .pop    (rd_data),
        .din    (rx_data),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
        .clk    (clk),
        .resetE (resetE),
        .push   (wr_data),
        .pop    (tx_valid & tx_ready),
        .din    (WriteData[WIDTH-1:0]),
        .dout   (tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    // STATUS word assembled from live FIFO state and sticky error bits
    always_comb begin
        status = '0;
        status[ST_RX_NONEMPTY]    = ~rx_empty;
        status[ST_RX_FULL]        = rx_full;
        status[ST_TX_EMPTY]       = tx_empty;
        status[ST_TX_FULL]        = tx_full;
        status[ST_RX_UNDERFLOW]   = rx_underflow;
        status[ST_TX_OVERFLOW]    = tx_overflow;
        status[ST_RX_COUNT +: 8]  = 8'(rx_count);
    end

    // load data reflects pre-edge state; misses read as zero
    always_comb begin
        ReadData = !hit ? '0 : sel == REG_DATA ? 32'(rx_dout) : sel == REG_STATUS ? status : '0;
    end

    // sticky error bits: a new error wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!resetE) begin
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rx_underflow <= (rx_underflow & ~clr) | (rd_data & rx_empty);
            tx_overflow  <= (tx_overflow & ~clr) | (wr_data & tx_full);
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and randomized checks against a queue-based model
module tb_io_port_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 0, resetE = 0;
    logic [31:0] DataAdr = 0, WriteData = 0, ReadData;
    logic        MemWrite = 0, MemtoReg = 0, hit;
    logic [7:0]  rx_data = 0, tx_data;
    logic        rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;

    int n_cmp = 0, n_err = 0;
    logic [7:0] rxq[$], txq[$];
    bit m_unf = 0, m_ovf = 0;

    always #5 clk = ~clk;

    io_port_ctrl dut (
        .clk(clk), .resetE(resetE), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ReadData(ReadData), .hit(hit),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    function automatic logic [31:0] m_status();
        return {16'd0, 8'(rxq.size()), 2'd0, m_ovf, m_unf, txq.size() == DEPTH,
                txq.size() == 0, rxq.size() == DEPTH, rxq.size() != 0};
    endfunction

    function automatic logic [31:0] m_rdata(logic [31:0] a);
        if (a[31:4] != 28'h80) return 0;
        if (a[3:2] == 0) return rxq.size() != 0 ? {24'd0, rxq[0]} : 0;
        if (a[3:2] == 1) return m_status();
        return 0;
    endfunction

    task automatic drive(logic [31:0] a, logic [31:0] wd, logic mw, logic mr,
                         logic rv, logic [7:0] rd, logic tr);
        DataAdr = a; WriteData = wd; MemWrite = mw; MemtoReg = mr;
        rx_valid = rv; rx_data = rd; tx_ready = tr;
        #1;
    endtask

    // advance one clock edge and apply the same transfer rules to the model
    task automatic step();
        bit h = DataAdr[31:4] == 28'h80;
        bit rd = h && MemtoReg && DataAdr[3:2] == 0;
        bit wr = h && MemWrite && DataAdr[3:2] == 0;
        bit cl = h && MemWrite && DataAdr[3:2] == 2 && WriteData[0];
        bit rxp = rx_valid && rxq.size() < DEPTH;
        bit txp = tx_ready && txq.size() > 0;
        bit su = rd && rxq.size() == 0;
        bit so = wr && txq.size() == DEPTH;
        logic [7:0] rb = rx_data;
        logic [7:0] wb = WriteData[7:0];
        @(posedge clk);
        if (!resetE) begin
            rxq.delete(); txq.delete(); m_unf = 0; m_ovf = 0;
        end else begin
            if (rd && !su) void'(rxq.pop_front());
            if (rxp) rxq.push_back(rb);
            if (txp) void'(txq.pop_front());
            if (wr && !so) txq.push_back(wb);
            m_unf = (m_unf && !cl) || su;
            m_ovf = (m_ovf && !cl) || so;
        end
        #1;
    endtask

    task automatic test_reset();
        resetE = 0;
        drive(0, 0, 0, 0, 1, 8'h5A, 0);
        step();
        drive(32'h804, 0, 0, 1, 1, 8'h5A, 0);
        n_cmp++; if (rx_ready !== 1'b0) begin $display("FAIL reset_rx_ready got %0b want 0", rx_ready); n_err++; end
        n_cmp++; if (tx_valid !== 1'b0) begin $display("FAIL reset_tx_valid got %0b want 0", tx_valid); n_err++; end
        n_cmp++; if (tx_data !== 8'h00) begin $display("FAIL reset_tx_data got %h want 00", tx_data); n_err++; end
        n_cmp++; if (ReadData !== 32'h4) begin $display("FAIL reset_status got %h want 00000004", ReadData); n_err++; end
        step();
        resetE = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rx_ready !== 1'b1) begin $display("FAIL post_reset_rx_ready got %0b want 1", rx_ready); n_err++; end
    endtask

    task automatic test_rx_fill();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, b[i], 0);
            n_cmp++; if (rx_ready !== 1'b1) begin $display("FAIL fill_rx_ready[%0d] got %0b want 1", i, rx_ready); n_err++; end
            step();
        end
        drive(32'h804, 0, 0, 1, 1, 8'h55, 0);
        n_cmp++; if (rx_ready !== 1'b0) begin $display("FAIL fill_rx_ready_full got %0b want 0", rx_ready); n_err++; end
        n_cmp++; if (ReadData !== 32'h0000_0407) begin $display("FAIL fill_status got %h want 00000407", ReadData); n_err++; end
        step();
    endtask

    task automatic test_rx_drain();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(32'h800, 0, 0, 1, 0, 0, 0);
            n_cmp++; if (ReadData !== {24'd0, b[i]}) begin $display("FAIL drain_data[%0d] got %h want %h", i, ReadData, b[i]); n_err++; end
            step();
        end
        drive(32'h800, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h0) begin $display("FAIL drain_empty_load got %h want 0", ReadData); n_err++; end
        step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h14) begin $display("FAIL underflow_status got %h want 00000014", ReadData); n_err++; end
        drive(32'h808, 1, 1, 0, 0, 0, 0);
        step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h4) begin $display("FAIL underflow_clear got %h want 00000004", ReadData); n_err++; end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] b [5] = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 5; i++) begin
            drive(32'h800, {24'hFFFFFF, b[i]}, 1, 0, 0, 0, 0);
            step();
        end
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h28) begin $display("FAIL tx_overflow_status got %h want 00000028", ReadData); n_err++; end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin $display("FAIL tx_drain[%0d] got %0b/%h want 1/%h", i, tx_valid, tx_data, b[i]); n_err++; end
            step();
        end
        drive(32'h808, 1, 1, 0, 0, 0, 1);
        n_cmp++; if (tx_valid !== 1'b0) begin $display("FAIL tx_drain_end got %0b want 0", tx_valid); n_err++; end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] tb4 [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        drive(0, 0, 0, 0, 1, 8'h61, 0); step();
        drive(0, 0, 0, 0, 1, 8'h62, 0); step();
        drive(32'h800, 0, 0, 1, 1, 8'h63, 0);
        n_cmp++; if (ReadData !== 32'h61) begin $display("FAIL b2b_rx_head got %h want 61", ReadData); n_err++; end
        step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData[15:8] !== 8'd2) begin $display("FAIL b2b_rx_count got %0d want 2", ReadData[15:8]); n_err++; end
        drive(32'h800, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h62) begin $display("FAIL b2b_rx_order0 got %h want 62", ReadData); n_err++; end
        step();
        drive(32'h800, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h63) begin $display("FAIL b2b_rx_order1 got %h want 63", ReadData); n_err++; end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(32'h800, {24'd0, tb4[i]}, 1, 0, 0, 0, 0); step();
        end
        drive(32'h800, 32'h77, 1, 0, 0, 0, 1); step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData[5] !== 1'b1 || ReadData[3] !== 1'b0) begin $display("FAIL b2b_tx_ovf got %h want bit5=1 bit3=0", ReadData); n_err++; end
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            n_cmp++; if (tx_data !== tb4[i]) begin $display("FAIL b2b_tx_drain[%0d] got %h want %h", i, tx_data, tb4[i]); n_err++; end
            step();
        end
        drive(32'h808, 1, 1, 0, 0, 0, 1);
        n_cmp++; if (tx_valid !== 1'b0) begin $display("FAIL b2b_tx_dropped got %0b want 0", tx_valid); n_err++; end
        step();
    endtask

    task automatic test_decode();
        drive(32'h800, 32'hC3, 1, 0, 1, 8'h99, 0); step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h101) begin $display("FAIL dec_status got %h want 00000101", ReadData); n_err++; end
        drive(32'h804, 32'hFFFF_FFFF, 1, 0, 0, 0, 0); step();
        drive(32'h80C, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h0) begin $display("FAIL dec_rsvd got %h want 0", ReadData); n_err++; end
        step();
        drive(32'h900, 32'h5, 1, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h0 || hit !== 1'b0) begin $display("FAIL dec_miss got %h/%0b want 0/0", ReadData, hit); n_err++; end
        step();
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h101) begin $display("FAIL dec_nochange got %h want 00000101", ReadData); n_err++; end
        n_cmp++; if (tx_data !== 8'hC3) begin $display("FAIL dec_tx_head got %h want c3", tx_data); n_err++; end
        drive(32'h800, 0, 0, 1, 0, 0, 1); step();
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 3; i++) begin
            drive(32'h800, 32'hE1 + i, 1, 0, 1, 8'hD1 + 8'(i), 0); step();
        end
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (ReadData !== 32'h301) begin $display("FAIL mid_status got %h want 00000301", ReadData); n_err++; end
        resetE = 0;
        drive(32'h800, 32'h42, 1, 0, 1, 8'h42, 1);
        n_cmp++; if (rx_ready !== 1'b0) begin $display("FAIL mid_rx_ready_low got %0b want 0", rx_ready); n_err++; end
        step();
        n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin $display("FAIL mid_tx got %0b/%h want 0/00", tx_valid, tx_data); n_err++; end
        resetE = 1;
        drive(32'h804, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (rx_ready !== 1'b1) begin $display("FAIL mid_rx_ready_high got %0b want 1", rx_ready); n_err++; end
        n_cmp++; if (ReadData !== 32'h4) begin $display("FAIL mid_counts got %h want 00000004", ReadData); n_err++; end
    endtask

    task automatic test_random();
        logic [31:0] adrs [6] = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h900, 32'h810};
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            resetE = $urandom_range(0, 39) != 0;
            a = adrs[$urandom_range(0, 5)];
            drive(a, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom), 8'($urandom), 1'($urandom));
            n_cmp++; if (ReadData !== m_rdata(a)) begin $display("FAIL rnd_rdata[%0d] got %h want %h", i, ReadData, m_rdata(a)); n_err++; end
            n_cmp++; if (hit !== (a[31:4] == 28'h80)) begin $display("FAIL rnd_hit[%0d] got %0b", i, hit); n_err++; end
            n_cmp++; if (rx_ready !== (resetE && rxq.size() < DEPTH)) begin $display("FAIL rnd_rx_ready[%0d] got %0b want %0b", i, rx_ready, resetE && rxq.size() < DEPTH); n_err++; end
            n_cmp++; if (tx_valid !== (txq.size() != 0)) begin $display("FAIL rnd_tx_valid[%0d] got %0b want %0b", i, tx_valid, txq.size() != 0); n_err++; end
            n_cmp++; if (tx_data !== (txq.size() != 0 ? txq[0] : 8'h00)) begin $display("FAIL rnd_tx_data[%0d] got %h", i, tx_data); n_err++; end
            step();
        end
        resetE = 1;
    endtask

    initial begin
        test_reset();
        test_rx_fill();
        test_rx_drain();
        test_tx_overflow();
        test_back_to_back();
        test_decode();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
